led_pattern_sequencer: RTL and testbench

//  Avalon-MM controller that sequences the 8-bit LED PIO output autonomously.
//  The CPU loads a pattern table, step period and length through a slave port.
//  The block then replays the table by issuing single-cycle master writes to PIO

---
 rtl/led_pattern_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_led_pattern_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_sequencer.sv
// led_pattern_sequencer
// Avalon-MM block that replays a CPU-loaded pattern table onto the LED PIO.
// The CPU configures the block through a zero-wait slave port. The block then
// issues single-cycle master writes to PIO register 0 at a programmable step period.
module led_pattern_sequencer #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned PERIOD_WIDTH = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  s_address,
    input  logic        s_chipselect,
    input  logic        s_write_n,
    input  logic [31:0] s_writedata,
    output logic [31:0] s_readdata,
    output logic [1:0]  m_address,
    output logic        m_chipselect,
    output logic        m_write_n,
    output logic [31:0] m_writedata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_WAIT
    } state_t;

    // Configuration registers
    logic                    enable_q;
    logic                    oneshot_q;
    logic [PERIOD_WIDTH-1:0] period_q;
    logic [31:0]             length_q;
    logic [DATA_WIDTH-1:0]   pattern_q [DEPTH];

    // Sequencer state and registered master outputs
    state_t                  state_q;
    logic [2:0]              index_q;
    logic [PERIOD_WIDTH-1:0] count_q;
    logic                    m_cs_q;
    logic                    m_wn_q;
    logic [DATA_WIDTH-1:0]   m_data_q;

    // Decoded / derived values
    logic                    cpu_wr;
    logic                    ctrl_wr;
    logic                    pat_hit;
    logic [2:0]              pat_sel;
    logic [PERIOD_WIDTH-1:0] eff_period;
    logic [3:0]              eff_len;
    logic                    wrap_d;
    logic [2:0]              index_d;
    logic                    step_done;
    logic                    busy;

    // Slave write decode
    always_comb begin
        cpu_wr  = s_chipselect && !s_write_n;
        ctrl_wr = cpu_wr && (s_address == 4'd0);
        pat_sel = s_address[2:0];
        pat_hit = s_address[3] && (32'(pat_sel) < DEPTH);
    end

    // Effective period/length after clamping, and the next table index
    always_comb begin
        if (period_q == '0) begin
            eff_period = PERIOD_WIDTH'(1);
        end else begin
            eff_period = period_q;
        end

        if (length_q == '0) begin
            eff_len = 4'd1;
        end else if (length_q > 32'(DEPTH)) begin
            eff_len = 4'(DEPTH);
        end else begin
            eff_len = length_q[3:0];
        end

        // >= rather than == so a LENGTH shrunk below the current index wraps on the next advance
        wrap_d  = ({1'b0, index_q} >= (eff_len - 4'd1));
        index_d = wrap_d ? '0 : (index_q + 3'd1);
    end

    // A step expires when its eff_period clocks (the WRITE cycle included) have elapsed.
    // The WRITE cycle is counted as the step's first clock, so WAIT loads eff_period-2 and a
    // period of 1 goes WRITE->WRITE directly; strobes then land exactly eff_period clocks apart.
    always_comb begin
        step_done = enable_q &&
                    (((state_q == S_WRITE) && (eff_period == PERIOD_WIDTH'(1))) ||
                     ((state_q == S_WAIT)  && (count_q == '0)));
        busy      = (state_q != S_IDLE);
    end

    // Period, length and pattern table registers written by the CPU
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            period_q <= '0;
            length_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pattern_q[i] <= '0;
            end
        end else if (cpu_wr) begin
            if (s_address == 4'd1) begin
                period_q <= s_writedata[PERIOD_WIDTH-1:0];
            end
            if (s_address == 4'd2) begin
                length_q <= s_writedata;
            end
            if (pat_hit) begin
                pattern_q[pat_sel] <= s_writedata[DATA_WIDTH-1:0];
            end
        end
    end

    // Sequencer FSM with registered master strobe; also owns CTRL since oneshot clears enable
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            index_q   <= '0;
            count_q   <= '0;
            enable_q  <= 1'b0;
            oneshot_q <= 1'b0;
            m_cs_q    <= 1'b0;
            m_wn_q    <= 1'b1;
            m_data_q  <= '0;
        end else begin
            m_cs_q <= 1'b0;
            m_wn_q <= 1'b1;

            unique case (state_q)
                S_IDLE: begin
                    if (enable_q) begin
                        state_q  <= S_WRITE;
                        index_q  <= '0;
                        m_cs_q   <= 1'b1;
                        m_wn_q   <= 1'b0;
                        m_data_q <= pattern_q[0];
                    end
                end

                S_WRITE, S_WAIT: begin
                    if (!enable_q) begin
                        state_q <= S_IDLE;
                    end else if (step_done) begin
                        index_q <= index_d;
                        if (wrap_d && oneshot_q) begin
                            enable_q <= 1'b0;
                            state_q  <= S_IDLE;
                        end else begin
                            state_q  <= S_WRITE;
                            m_cs_q   <= 1'b1;
                            m_wn_q   <= 1'b0;
                            m_data_q <= pattern_q[index_d];
                        end
                    end else if (state_q == S_WRITE) begin
                        count_q <= eff_period - PERIOD_WIDTH'(2);
                        state_q <= S_WAIT;
                    end else begin
                        count_q <= count_q - PERIOD_WIDTH'(1);
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase

            // Placed last so a CPU CTRL write overrides the oneshot auto-clear
            if (ctrl_wr) begin
                enable_q  <= s_writedata[0];
                oneshot_q <= s_writedata[1];
            end
        end
    end

    // Zero-wait combinational read mux
    always_comb begin
        s_readdata = '0;
        case (s_address)
            4'd0:    s_readdata[1:0] = {oneshot_q, enable_q};
            4'd1:    s_readdata = 32'(period_q);
            4'd2:    s_readdata = length_q;
            4'd3:    s_readdata = {25'd0, index_q, 3'd0, busy};
            default: begin
                if (pat_hit) begin
                    s_readdata[DATA_WIDTH-1:0] = pattern_q[pat_sel];
                end
            end
        endcase
    end

    assign m_address    = 2'b00;
    assign m_chipselect = m_cs_q;
    assign m_write_n    = m_wn_q;
    assign m_writedata  = 32'(m_data_q);

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// tb_led_pattern_sequencer
// Scoreboard bench: each run pushes the expected PIO writes (data and cycle stamp),
// and a negedge monitor pops and compares every master strobe the DUT issues.
module tb_led_pattern_sequencer;

    localparam int unsigned DEPTH = 8;

    typedef struct {
        logic [31:0] data;
        int unsigned t;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  s_address = '0;
    logic        s_chipselect = 1'b0;
    logic        s_write_n = 1'b1;
    logic [31:0] s_writedata = '0;
    logic [31:0] s_readdata;
    logic [1:0]  m_address;
    logic        m_chipselect;
    logic        m_write_n;
    logic [31:0] m_writedata;

    exp_t        sb [$];
    exp_t        mon_e;
    exp_t        f_e;
    int unsigned f_t0;
    int unsigned cyc = 0;
    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    logic [7:0]  pat_m [DEPTH];

    led_pattern_sequencer #(
        .DATA_WIDTH  (8),
        .DEPTH       (DEPTH),
        .PERIOD_WIDTH(32)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .s_address   (s_address),
        .s_chipselect(s_chipselect),
        .s_write_n   (s_write_n),
        .s_writedata (s_writedata),
        .s_readdata  (s_readdata),
        .m_address   (m_address),
        .m_chipselect(m_chipselect),
        .m_write_n   (m_write_n),
        .m_writedata (m_writedata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic cpu_write(input logic [3:0] a, input logic [31:0] d);
        s_address    = a;
        s_writedata  = d;
        s_chipselect = 1'b1;
        s_write_n    = 1'b0;
        @(negedge clk);
        s_chipselect = 1'b0;
        s_write_n    = 1'b1;
    endtask

    task automatic rd_check(input string tag, input logic [3:0] a, input logic [31:0] exp);
        s_address = a;
        #1;
        check_eq(tag, s_readdata, exp);
    endtask

    task automatic wait_until(input int unsigned t);
        int unsigned guard = 0;
        while (cyc < t && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        check_eq("sync", cyc, t);
    endtask

    function automatic int unsigned eff_len_m(input int unsigned l);
        if (l == 0) return 1;
        if (l > DEPTH) return DEPTH;
        return l;
    endfunction

    function automatic int unsigned eff_per_m(input int unsigned p);
        return (p == 0) ? 1 : p;
    endfunction

    // Every strobe must be expected, well formed, carry the right data and land on its cycle
    always @(negedge clk) begin
        if (m_chipselect || !m_write_n) begin
            check_eq("strobe_expected", 32'(sb.size() != 0), 32'd1);
            check_eq("strobe_shape", {30'd0, m_chipselect, m_write_n}, 32'd2);
            check_eq("m_address", 32'(m_address), 32'd0);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                check_eq("strobe_data", m_writedata, mon_e.data);
                check_eq("strobe_time", cyc, mon_e.t);
            end
        end
    end

    // Configure, start, then either let oneshot end it or clear enable at last+stop_off
    task automatic run_case(input int unsigned len_w, input int unsigned per_w,
                            input logic [31:0] ctrl, input int unsigned n_req, input int stop_off);
        int unsigned el = eff_len_m(len_w);
        int unsigned ep = eff_per_m(per_w);
        int unsigned n  = ctrl[1] ? el : n_req;
        int unsigned t0;
        int unsigned last;
        exp_t        e;
        cpu_write(4'd2, len_w);
        cpu_write(4'd1, per_w);
        rd_check("length_rb", 4'd2, len_w);
        rd_check("period_rb", 4'd1, per_w);
        @(negedge clk);
        cpu_write(4'd0, ctrl);
        t0 = cyc + 1;
        for (int unsigned i = 0; i < n; i++) begin
            e.data = 32'(pat_m[i % el]);
            e.t    = t0 + i * ep;
            sb.push_back(e);
        end
        last = t0 + (n - 1) * ep;
        if (ctrl[1]) begin
            wait_until(last + ep + 2);
            rd_check("oneshot_status", 4'd3, 32'd0);
            rd_check("oneshot_ctrl", 4'd0, 32'd2);
        end else begin
            wait_until(32'(int'(last) + stop_off));
            cpu_write(4'd0, 32'd0);
            @(negedge clk);
            rd_check("stop_status", 4'd3, 32'(((n - 1) % el) << 4));
        end
        repeat (3 * ep + 6) @(negedge clk);
        check_eq("sb_drained", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_m_cs", 32'(m_chipselect), 32'd0);
        check_eq("rst_m_write_n", 32'(m_write_n), 32'd1);
        check_eq("rst_m_writedata", m_writedata, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int unsigned a = 0; a < 16; a++) begin
            @(negedge clk);
            rd_check("rst_read", 4'(a), 32'd0);
        end

        // Pattern table: one-hot walk; entry 7 written with extra upper bits
        for (int unsigned i = 0; i < DEPTH; i++) begin
            pat_m[i] = 8'(1 << i);
            @(negedge clk);
            cpu_write(4'(8 + i), (i == 7) ? 32'h0000_0180 : 32'(pat_m[i]));
        end
        rd_check("pat7_mask", 4'd15, 32'h0000_0080);
        rd_check("pat2_rb", 4'd10, 32'h0000_0004);
        @(negedge clk);
        cpu_write(4'd4, 32'hFFFF_FFFF);
        rd_check("unmapped_rd", 4'd4, 32'd0);
        @(negedge clk);
        cpu_write(4'd0, 32'hFFFF_FFFC);
        rd_check("ctrl_mask", 4'd0, 32'd0);
        @(negedge clk);

        run_case(3, 4, 32'd1, 7, -1);   // free run, enable cleared as a strobe is issued
        run_case(3, 4, 32'd1, 5, 1);    // free run, enable cleared during WAIT
        run_case(3, 4, 32'd3, 0, 0);    // oneshot: exactly one pass
        run_case(0, 0, 32'd1, 6, -1);   // zero period/length: PATTERN0 every clock
        run_case(12, 2, 32'd1, 10, -1); // length clamped to DEPTH

        // Reset asserted mid-WAIT
        cpu_write(4'd2, 32'd3);
        cpu_write(4'd1, 32'd4);
        @(negedge clk);
        cpu_write(4'd0, 32'd1);
        f_t0 = cyc + 1;
        for (int unsigned i = 0; i < 2; i++) begin
            f_e.data = 32'(pat_m[i]);
            f_e.t    = f_t0 + i * 4;
            sb.push_back(f_e);
        end
        wait_until(f_t0 + 5);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("mid_rst_m_cs", 32'(m_chipselect), 32'd0);
        check_eq("mid_rst_m_write_n", 32'(m_write_n), 32'd1);
        check_eq("mid_rst_m_writedata", m_writedata, 32'd0);
        rd_check("mid_rst_ctrl", 4'd0, 32'd0);
        rd_check("mid_rst_period", 4'd1, 32'd0);
        rd_check("mid_rst_length", 4'd2, 32'd0);
        rd_check("mid_rst_status", 4'd3, 32'd0);
        rd_check("mid_rst_pat0", 4'd8, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        check_eq("post_rst_drained", 32'(sb.size()), 32'd0);
        rd_check("post_rst_status", 4'd3, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
